// File: rtl/select_neighbors_win.sv
// Scans a latched snapshot one slot per cycle, writing in-window candidates as {payload, age}; done after DEPTH+1 cycles unstalled.
// Backpressure: a qualifying slot holds (no drop) while fifo_full is high; rejected slots never wait on the FIFO.
module select_neighbors_win #(
    parameter int DEPTH   = 16,
    parameter int T_WIDTH = 16,
    parameter int P_WIDTH = 32,
    parameter int DT_MAX  = 1024,
    parameter int MAX_OUT = 16,
    parameter int ORDER   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DEPTH-1:0]             cand_valid,
    input  logic [DEPTH*T_WIDTH-1:0]     cand_t,
    input  logic [DEPTH*P_WIDTH-1:0]     cand_payload,
    input  logic [T_WIDTH-1:0]           t_now,
    output logic                         fifo_wr_en,
    output logic [P_WIDTH+T_WIDTH-1:0]   fifo_din,
    input  logic                         fifo_full,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_OUT+1)-1:0] sel_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [IW-1:0]      IDX_FIRST = (ORDER == 1) ? IW'(DEPTH - 1) : IW'(0);
    localparam logic [IW-1:0]      IDX_LAST  = (ORDER == 1) ? IW'(0) : IW'(DEPTH - 1);
    localparam logic [CW-1:0]      CNT_MAX   = CW'(MAX_OUT);
    localparam logic [T_WIDTH-1:0] DT_LIM    = T_WIDTH'(DT_MAX);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH*T_WIDTH-1:0]   t_q;
    logic [DEPTH*P_WIDTH-1:0]   pay_q;
    logic [T_WIDTH-1:0]         tnow_q;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       load;

    logic [T_WIDTH-1:0]         cur_t;
    logic [P_WIDTH-1:0]         cur_p;
    logic [T_WIDTH-1:0]         age;
    logic                       qual;
    logic                       wr;

    // Subtraction on T_WIDTH bits gives the modular age, so wrap-around needs no special case.
    assign cur_t = t_q[idx_q*T_WIDTH +: T_WIDTH];
    assign cur_p = pay_q[idx_q*P_WIDTH +: P_WIDTH];
    assign age   = tnow_q - cur_t;
    assign qual  = valid_q[idx_q] && (age <= DT_LIM);
    assign wr    = (state_q == SCAN) && qual && !fifo_full;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q == SCAN);
    assign done       = (state_q == DONE);
    assign sel_count  = cnt_q;
    assign fifo_wr_en = wr;
    assign fifo_din   = wr ? {cur_p, age} : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = IDX_FIRST;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // A qualifying slot blocked by fifo_full stays put; everything else advances.
                if (!qual || !fifo_full) begin
                    if (qual) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if ((idx_q == IDX_LAST) || (qual && (cnt_d == CNT_MAX))) begin
                        state_d = DONE;
                    end else if (ORDER == 1) begin
                        idx_d = idx_q - IW'(1);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            t_q     <= '0;
            pay_q   <= '0;
            tnow_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (load) begin
                valid_q <= cand_valid;
                t_q     <= cand_t;
                pay_q   <= cand_payload;
                tnow_q  <= t_now;
            end
        end
    end
endmodule

// File: tb/tb_select_neighbors_win.sv
// Directed bench for select_neighbors_win: default, MAX_OUT=3 and ORDER=1 instances share the candidate bus.
module tb_select_neighbors_win;
    localparam int DEPTH = 16;
    localparam int TW    = 16;
    localparam int PW    = 32;
    localparam int DW    = PW + TW;

    typedef struct {
        int             k;
        int             c;
        logic [DW-1:0]  d;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [2:0]             in_valid_v;
    logic [DEPTH-1:0]       cand_valid;
    logic [DEPTH*TW-1:0]    cand_t;
    logic [DEPTH*PW-1:0]    cand_p;
    logic [TW-1:0]          t_now;
    logic                   fifo_full;
    logic [2:0]             rdy_v, wr_v, busy_v, done_v;
    logic [DW-1:0]          din_v [3];
    logic [4:0]             sc0, sc2;
    logic [1:0]             sc1;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    int  full_rel = 0;
    int  full_len = 0;
    int  viol = 0;
    wr_t wq[$];

    select_neighbors_win u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(rdy_v[0]),
        .cand_valid(cand_valid), .cand_t(cand_t), .cand_payload(cand_p), .t_now(t_now),
        .fifo_wr_en(wr_v[0]), .fifo_din(din_v[0]), .fifo_full(fifo_full),
        .busy(busy_v[0]), .done(done_v[0]), .sel_count(sc0)
    );

    select_neighbors_win #(.MAX_OUT(3)) u_max (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(rdy_v[1]),
        .cand_valid(cand_valid), .cand_t(cand_t), .cand_payload(cand_p), .t_now(t_now),
        .fifo_wr_en(wr_v[1]), .fifo_din(din_v[1]), .fifo_full(fifo_full),
        .busy(busy_v[1]), .done(done_v[1]), .sel_count(sc1)
    );

    select_neighbors_win #(.ORDER(1)) u_rev (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(rdy_v[2]),
        .cand_valid(cand_valid), .cand_t(cand_t), .cand_payload(cand_p), .t_now(t_now),
        .fifo_wr_en(wr_v[2]), .fifo_din(din_v[2]), .fifo_full(fifo_full),
        .busy(busy_v[2]), .done(done_v[2]), .sel_count(sc2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fifo_full window is placed relative to the accept edge of the current snapshot.
    always @(posedge clk) begin
        #2;
        fifo_full = (full_len > 0) && (cyc - acc_cyc >= full_rel) && (cyc - acc_cyc < full_rel + full_len);
    end

    always @(negedge clk) begin
        wr_t w;
        for (int k = 0; k < 3; k++) begin
            if (wr_v[k]) begin
                w.k = k;
                w.c = cyc;
                w.d = din_v[k];
                wq.push_back(w);
                if (fifo_full) viol++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pay(input int slot);
        return 32'hA500_0000 | slot;
    endfunction

    function automatic int sc_of(input int k);
        if (k == 0) return int'(sc0);
        if (k == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    task automatic clear_cands();
        cand_valid = '0;
        cand_t     = '0;
        cand_p     = '0;
    endtask

    task automatic set_slot(input int i, input logic [TW-1:0] t);
        cand_valid[i]       = 1'b1;
        cand_t[i*TW +: TW]  = t;
        cand_p[i*PW +: PW]  = pay(i);
    endtask

    task automatic chk_wr(input string tag, input int i, input int k, input int slot,
                          input logic [TW-1:0] age, input int rel);
        logic [DW-1:0] e;
        e = {pay(slot), age};
        if (i < wq.size()) begin
            chk({tag, "_inst"}, wq[i].k, k);
            chk({tag, "_dat"}, wq[i].d, e);
            chk({tag, "_cyc"}, wq[i].c - acc_cyc, rel);
        end else begin
            chk({tag, "_missing"}, wq.size(), i + 1);
        end
    endtask

    // Offers one snapshot to instance k and waits (bounded) for done; lat counts the accept cycle as 1.
    task automatic run(input int k, input bit hold, output int lat, output int sc);
        bit rdy_bad;
        chk($sformatf("rdy_idle_%0d", k), rdy_v[k], 1);
        wq.delete();
        in_valid_v[k] = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) in_valid_v[k] = 1'b0;
        lat = -1;
        sc = -1;
        rdy_bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_v[k]) begin
                lat = cyc - acc_cyc + 1;
                sc = sc_of(k);
                in_valid_v[k] = 1'b0;
                break;
            end
            if (rdy_v[k]) rdy_bad = 1'b1;
        end
        chk($sformatf("rdy_low_in_scan_%0d", k), rdy_bad, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, sc;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sc;
        rst = 1'b1;
        in_valid_v = '0;
        fifo_full = 1'b0;
        t_now = '0;
        clear_cands();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", rdy_v, 3'b000);
        chk("rst_wr_en", wr_v, 3'b000);
        chk("rst_din", din_v[0], 0);
        chk("rst_busy", busy_v, 3'b000);
        chk("rst_done", done_v, 3'b000);
        chk("rst_sel_count", sc0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", rdy_v, 3'b111);

        // Basic window with wrap-around and a future timestamp.
        clear_cands();
        set_slot(13, 16'd0);
        set_slot(14, 16'd1);
        set_slot(15, 16'd65534);
        t_now = 16'd0;
        run(0, 1'b0, lat, sc);
        chk("basic_lat", lat, 17);
        chk("basic_sel", sc, 2);
        chk("basic_nwr", wq.size(), 2);
        chk_wr("basic_w0", 0, 0, 13, 16'd0, 13);
        chk_wr("basic_w1", 1, 0, 15, 16'd2, 15);
        chk("basic_sel_hold", sc0, 2);

        // Same snapshot with fifo_full high for 5 cycles starting when slot 13 is evaluated.
        full_rel = 13;
        full_len = 5;
        run(0, 1'b0, lat, sc);
        full_len = 0;
        chk("bp_lat", lat, 22);
        chk("bp_sel", sc, 2);
        chk("bp_nwr", wq.size(), 2);
        chk_wr("bp_w0", 0, 0, 13, 16'd0, 18);
        chk_wr("bp_w1", 1, 0, 15, 16'd2, 20);

        // MAX_OUT=3 with every slot qualifying at age 5.
        clear_cands();
        for (int i = 0; i < DEPTH; i++) set_slot(i, 16'd100);
        t_now = 16'd105;
        run(1, 1'b0, lat, sc);
        chk("max_lat", lat, 4);
        chk("max_sel", sc, 3);
        chk("max_nwr", wq.size(), 3);
        chk_wr("max_w0", 0, 1, 0, 16'd5, 0);
        chk_wr("max_w1", 1, 1, 1, 16'd5, 1);
        chk_wr("max_w2", 2, 1, 2, 16'd5, 2);

        // ORDER=1: slots 2 and 9 qualify, slot 5 is in the future.
        clear_cands();
        set_slot(2, 16'd40);
        set_slot(9, 16'd40);
        set_slot(5, 16'd60);
        t_now = 16'd50;
        run(2, 1'b0, lat, sc);
        chk("rev_lat", lat, 17);
        chk("rev_sel", sc, 2);
        chk("rev_nwr", wq.size(), 2);
        chk_wr("rev_w0", 0, 2, 9, 16'd10, 6);
        chk_wr("rev_w1", 1, 2, 2, 16'd10, 13);

        // Age boundary, with in_valid held high throughout the scan.
        clear_cands();
        set_slot(3, 16'd3976);
        set_slot(7, 16'd3975);
        set_slot(10, 16'd5001);
        set_slot(11, 16'd5000);
        t_now = 16'd5000;
        run(0, 1'b1, lat, sc);
        chk("bnd_lat", lat, 17);
        chk("bnd_sel", sc, 2);
        chk("bnd_nwr", wq.size(), 2);
        chk_wr("bnd_w0", 0, 0, 3, 16'd1024, 3);
        chk_wr("bnd_w1", 1, 0, 11, 16'd0, 11);
        chk("bnd_no_relatch", busy_v[0], 0);

        // Reset after two writes of a full-age-0 snapshot.
        clear_cands();
        for (int i = 0; i < DEPTH; i++) set_slot(i, 16'd100);
        t_now = 16'd100;
        wq.delete();
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid_v[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (wq.size() >= 2) break;
        end
        chk("mid_nwr_before", wq.size(), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", wr_v[0], 0);
        chk("mid_rst_din", din_v[0], 0);
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_sel", sc0, 0);
        chk("mid_rst_rdy", rdy_v[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_nwr_after", wq.size(), 2);
        @(posedge clk);
        #1;
        chk("mid_rdy_release", rdy_v[0], 1);
        clear_cands();
        set_slot(13, 16'd0);
        set_slot(14, 16'd1);
        set_slot(15, 16'd65534);
        t_now = 16'd0;
        run(0, 1'b0, lat, sc);
        chk("again_lat", lat, 17);
        chk("again_sel", sc, 2);
        chk("again_nwr", wq.size(), 2);
        chk_wr("again_w0", 0, 0, 13, 16'd0, 13);
        chk_wr("again_w1", 1, 0, 15, 16'd2, 15);

        chk("wr_while_full", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
